// File: rtl/eth_rx_uart_bridge_if.sv
// RX buffer side of the bridge: frame-ready strobe with length, and the buffer RAM read port.
interface eth_rx_uart_bridge_if #(
  parameter int W = 9
);
  logic         rx_done;
  logic [W-1:0] rx_len;
  logic [W-1:0] buf_rdaddr;
  logic [15:0]  buf_rddata;

  modport master (output rx_done, rx_len, buf_rddata, input buf_rdaddr);
  modport slave  (input rx_done, rx_len, buf_rddata, output buf_rdaddr);
endinterface

// File: rtl/eth_rx_uart_bridge.sv
// Streams a received Ethernet frame from the RX buffer RAM out of a UART, high byte of each word first.
// Optional even parity per byte when ETH_RX_UART_PARITY_EN is defined (8E1), otherwise 8N1.
module eth_rx_uart_bridge #(
  parameter int CLK_FREQ            = 100,
  parameter int BAUD                = 115200,
  parameter int ETH_RX_BUFFER_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  eth_rx_uart_bridge_if.slave  rxb,
  output logic                 uart_txd,
  output logic                 busy,
  output logic                 overrun
);

  localparam int W   = ETH_RX_BUFFER_WIDTH;
  localparam int DIV = (CLK_FREQ * 1000000) / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef ETH_RX_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam logic [BW-1:0] DIV_LAST = BW'(DIV - 1);
  localparam logic [3:0]    BIT_LAST = 4'(NBITS - 1);
  localparam logic [W:0]    CNT_ONE  = (W+1)'(1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND_HI, SEND_LO} state_t;

  state_t        state;
  logic          armed;
  logic [W-1:0]  len_q;
  logic [15:0]   word_q;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    cur_byte;
  logic [W:0]    words_sent;

  // Line level for position idx of a byte frame: start, data LSB first, [parity], stop.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic v;
    v = 1'b1;
    if (idx == 4'd0)
      v = 1'b0;
    else if (idx <= 4'd8)
      v = b[3'(idx - 4'd1)];
`ifdef ETH_RX_UART_PARITY_EN
    else if (idx == 4'd9)
      v = ^b;
`endif
    return v;
  endfunction

  assign cur_byte   = (state == SEND_HI) ? word_q[15:8] : word_q[7:0];
  assign words_sent = {1'b0, rxb.buf_rdaddr} + CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      armed          <= 1'b0;
      len_q          <= '0;
      word_q         <= '0;
      baud_cnt       <= '0;
      bit_cnt        <= '0;
      rxb.buf_rdaddr <= '0;
      uart_txd       <= 1'b1;
      busy           <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      armed   <= 1'b1;
      // busy is still high on the edge where the last stop bit ends, so that strobe is dropped too.
      overrun <= rxb.rx_done && busy;
      case (state)
        IDLE: begin
          if (armed && rxb.rx_done && (rxb.rx_len != '0)) begin
            len_q          <= rxb.rx_len;
            rxb.buf_rdaddr <= '0;
            busy           <= 1'b1;
            state          <= FETCH;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          word_q   <= rxb.buf_rddata;
          uart_txd <= 1'b0;
          bit_cnt  <= '0;
          baud_cnt <= '0;
          state    <= SEND_HI;
        end
        SEND_HI, SEND_LO: begin
          if (baud_cnt != DIV_LAST) begin
            baud_cnt <= baud_cnt + BW'(1);
          end else begin
            baud_cnt <= '0;
            if (bit_cnt != BIT_LAST) begin
              bit_cnt  <= bit_cnt + 4'd1;
              uart_txd <= frame_bit(cur_byte, bit_cnt + 4'd1);
            end else if (state == SEND_HI) begin
              bit_cnt  <= '0;
              uart_txd <= 1'b0;
              state    <= SEND_LO;
            end else if (words_sent < {1'b0, len_q}) begin
              rxb.buf_rdaddr <= rxb.buf_rdaddr + W'(1);
              state          <= FETCH;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/eth_rx_uart_bridge.md
ETH_RX_UART_BRIDGE -- requirements
Module: eth_rx_uart_bridge

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100, system clock frequency in MHz.
REQ-002 SHALL have parameter BAUD, default 115200, UART bit rate in bit/s.
REQ-003 SHALL have parameter ETH_RX_BUFFER_WIDTH, default 9, RX buffer word-address width W.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rx_done  input  1  one-cycle pulse: a complete frame is in the RX buffer RAM.
REQ-007 SHALL have port rx_len  input  W  frame length in 16-bit words, valid with rx_done.
REQ-008 SHALL have port buf_rdaddr  output  W  RX buffer RAM read address.
REQ-009 SHALL have port buf_rddata  input  16  RX buffer RAM read data, one-cycle registered latency.
REQ-010 SHALL have port uart_txd  output  1  UART serial output, idle high.
REQ-011 SHALL have port busy  output  1  high from frame acceptance until the final stop bit ends.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse when rx_done is dropped.

Function
REQ-013 SHALL compute bit period DIV = (CLK_FREQ*1000000)/BAUD, truncated; the 100 MHz/115200 default gives 868 cycles.
REQ-014 SHALL use states IDLE, FETCH, WAIT, SEND_HI, SEND_LO.
REQ-015 IDLE: rx_done=1 with rx_len!=0 SHALL latch rx_len, set buf_rdaddr=0, assert busy the next cycle, and go to FETCH.
REQ-016 IDLE: rx_done=1 with rx_len=0 SHALL be ignored: no busy, no overrun, no output.
REQ-017 FETCH SHALL present buf_rdaddr for one cycle, and WAIT SHALL capture buf_rddata into a 16-bit word register on the following cycle.
REQ-018 SHALL transmit each word high byte (data[15:8]) first in SEND_HI, then the low byte in SEND_LO.
REQ-019 Each byte SHALL be sent as start bit 0, eight data bits LSB first, then stop bit 1, each bit held exactly DIV cycles.
REQ-020 uart_txd SHALL fall for the first start bit no later than 4 cycles after the accepting rx_done.
REQ-021 After SEND_LO stop bit: if words sent < latched length, SHALL increment buf_rdaddr and go to FETCH; else go to IDLE and deassert busy.
REQ-022 Consecutive bytes within a frame SHALL have an inter-byte gap of at most 3 cycles.
REQ-023 rx_done while busy=1 SHALL be dropped, SHALL pulse overrun for exactly one cycle, and SHALL not disturb the frame in progress.
REQ-024 rx_done in the same cycle busy falls SHALL be treated as busy, i.e. dropped with overrun.
REQ-025 buf_rdaddr SHALL never exceed latched length minus 1 and SHALL not wrap.

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE, uart_txd=1, busy=0, overrun=0, buf_rdaddr=0, and clear the bit and baud counters.
REQ-027 Reset asserted mid-byte SHALL abort the frame; after release uart_txd SHALL stay 1 until a new accepted rx_done.
REQ-028 The first rx_done SHALL be accepted no earlier than the second clk edge after rst_n rises.

Configuration
REQ-029 Macro ETH_RX_UART_PARITY_EN defined: each byte SHALL carry an even-parity bit between bit 7 and the stop bit, making a frame of 11 bit periods.
REQ-030 Macro ETH_RX_UART_PARITY_EN undefined: the format SHALL be 8N1 with 10 bit periods and no parity logic synthesized.

Verification
REQ-031 Reset, then rx_done with rx_len=1 and RAM[0]=0xA55A -> bytes 0xA5 then 0x5A on uart_txd, each bit 868 cycles, busy falls after the second stop bit.
REQ-032 rx_len=3 with RAM = 0x0102, 0x0304, 0x0506 -> byte sequence 01 02 03 04 05 06, buf_rdaddr steps 0, 1, 2 and never reaches 3.
REQ-033 rx_done pulse at the midpoint of a frame -> overrun high exactly one cycle, and the original frame is completed byte-exact.
REQ-034 rx_done with rx_len=0 -> busy stays 0, uart_txd stays 1 for 10000 cycles, no overrun.
REQ-035 rst_n low during data bit 4 of the first byte -> uart_txd=1 and busy=0 immediately; a following rx_done with rx_len=1 transmits correctly.
REQ-036 With ETH_RX_UART_PARITY_EN, word 0x0300 -> byte 0x03 with parity 0 and byte 0x00 with parity 0; word 0x0100 -> byte 0x01 with parity 1.
